// File: rtl/ad9516_pkg.sv
// Shared definitions for the AD9516 multi-chip configuration engine.
// Holds FSM state codes, serial word layout and well-known register addresses.
// No logic lives here; everything is constant.
package ad9516_pkg;

  // Controller state codes
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARB   = 3'd1;
  localparam logic [2:0] ST_RST   = 3'd2;
  localparam logic [2:0] ST_FETCH = 3'd3;
  localparam logic [2:0] ST_SHIFT = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;
  localparam logic [2:0] ST_LOCK  = 3'd6;

  // 24-bit serial word: [23:8] instruction (R/W, byte count, address), [7:0] data
  localparam int WORD_W    = 24;
  localparam int INSTR_MSB = 23;
  localparam int INSTR_LSB = 8;
  localparam int DATA_MSB  = 7;
  localparam int DATA_LSB  = 0;

  // Writing 0x01 here transfers buffered registers into the active set
  localparam logic [15:0] REG_UPDATE = 16'h0232;

endpackage

// File: rtl/ad9516_spi_tx.sv
// 24-bit MSB-first SPI serialiser with one-hot chip select fan-out.
// Latency: CS falls the cycle after load; frame is 48*SCLK_DIV cycles of CS low.
// Backpressure: load is accepted only while busy is low; ignored otherwise.
module ad9516_spi_tx
  import ad9516_pkg::*;
#(
  parameter int N_CHIP   = 2,
  parameter int SCLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [1:0]        sel,
  input  logic [WORD_W-1:0] word,
  output logic              busy,
  output logic [N_CHIP-1:0] cs,
  output logic [N_CHIP-1:0] sclk,
  output logic [N_CHIP-1:0] sdio
);

  localparam int DIV_W = $clog2(SCLK_DIV);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(SCLK_DIV - 1);

  logic              busy_q;
  logic [1:0]        sel_q;
  logic [WORD_W-1:0] sh;
  logic [4:0]        bit_cnt;
  logic [DIV_W-1:0]  half_cnt;
  logic              sclk_q;
  logic [N_CHIP-1:0] sel_mask;

  // Decode the latched chip index into a one-hot lane mask
  always_comb begin
    sel_mask = '0;
    for (int c = 0; c < N_CHIP; c++) sel_mask[c] = (sel_q == 2'(c));
  end

  // Only the selected lane ever leaves idle (CS=1, SCLK=0, SDIO=0)
  assign busy = busy_q;
  assign cs   = busy_q ? ~sel_mask : '1;
  assign sclk = sel_mask & {N_CHIP{sclk_q & busy_q}};
  assign sdio = sel_mask & {N_CHIP{sh[WORD_W-1] & busy_q}};

  // Half-period timer: SCLK rises mid-bit, falls at bit end where data shifts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      sel_q    <= '0;
      sh       <= '0;
      bit_cnt  <= '0;
      half_cnt <= '0;
      sclk_q   <= 1'b0;
    end else if (!busy_q) begin
      if (load) begin
        busy_q   <= 1'b1;
        sel_q    <= sel;
        sh       <= word;
        bit_cnt  <= '0;
        half_cnt <= '0;
        sclk_q   <= 1'b0;
      end
    end else if (half_cnt == HALF_LAST) begin
      half_cnt <= '0;
      if (!sclk_q) begin
        sclk_q <= 1'b1;
      end else begin
        sclk_q <= 1'b0;
        if (bit_cnt == 5'd23) begin
          busy_q <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
          sh      <= {sh[WORD_W-2:0], 1'b0};
        end
      end
    end else begin
      half_cnt <= half_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/ad9516_multi_cfg.sv
// Round-robin configurator: resets, programs and lock-checks up to four AD9516s.
// Latency: per chip 2*RST_LEN + REG_NUM*(frame+gap+fetch) cycles, then lock wait.
// Backpressure: start edges queue as pending bits; one chip is serviced at a time.
module ad9516_multi_cfg
  import ad9516_pkg::*;
#(
  parameter int N_CHIP       = 2,
  parameter int REG_NUM      = 64,
  parameter int SCLK_DIV     = 4,
  parameter int LOCK_TIMEOUT = 1_000_000,
  parameter int MAX_RETRY    = 3,
  parameter int RST_LEN      = 16
) (
  input  logic              sys_clk_i,
  input  logic              hw_arst_n,
  input  logic [N_CHIP-1:0] start_i,
  input  logic [N_CHIP-1:0] refsel_i,
  output logic [1:0]        cfg_chip_o,
  output logic [7:0]        cfg_idx_o,
  input  logic [WORD_W-1:0] cfg_word_i,
  output logic [N_CHIP-1:0] AD9516_CS,
  output logic [N_CHIP-1:0] AD9516_SCLK,
  output logic [N_CHIP-1:0] AD9516_SDIO,
  output logic [N_CHIP-1:0] AD9516_RESET_B,
  output logic [N_CHIP-1:0] AD9516_PD_B,
  output logic [N_CHIP-1:0] AD9516_REFSEL,
  input  logic [N_CHIP-1:0] AD9516_STATUS,
  output logic              busy_o,
  output logic [N_CHIP-1:0] done_o,
  output logic [N_CHIP-1:0] lock_o,
  output logic [N_CHIP-1:0] err_o
);

  localparam int TMR_A   = (LOCK_TIMEOUT > 2 * RST_LEN) ? LOCK_TIMEOUT : 2 * RST_LEN;
  localparam int TMR_MAX = (TMR_A > 2 * SCLK_DIV) ? TMR_A : 2 * SCLK_DIV;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int RTY_W   = $clog2(MAX_RETRY + 2);
  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(2 * RST_LEN - 1);
  localparam logic [TMR_W-1:0] RST_LOW  = TMR_W'(RST_LEN);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(2 * SCLK_DIV - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [7:0]       IDX_LAST = 8'(REG_NUM - 1);

  logic [2:0]        state;
  logic [1:0]        cur, last, grant;
  logic              found;
  logic [7:0]        idx;
  logic [RTY_W-1:0]  retry;
  logic [TMR_W-1:0]  timer;
  logic [3:0]        stable;
  logic [N_CHIP-1:0] pend, start_q, sts_s1, sts_s2, refsel_q, done, err;
  logic [N_CHIP-1:0] cur_mask, grant_mask, pend_clr, rise;
  logic              sts_cur, rst_low, tx_load, tx_busy;

  // Round-robin grant: scan from the chip after the last serviced one
  always_comb begin
    int c;
    c     = 0;
    grant = '0;
    found = 1'b0;
    for (int i = N_CHIP; i >= 1; i--) begin
      c = int'(last) + i;
      if (c >= N_CHIP) c = c - N_CHIP;
      if (pend[c]) begin
        grant = 2'(c);
        found = 1'b1;
      end
    end
  end

  // One-hot views of the current and granted chip
  always_comb begin
    cur_mask   = '0;
    grant_mask = '0;
    for (int c = 0; c < N_CHIP; c++) begin
      cur_mask[c]   = (cur == 2'(c));
      grant_mask[c] = (grant == 2'(c));
    end
  end

  assign rise     = start_i & ~start_q;
  assign pend_clr = (state == ST_ARB && found) ? grant_mask : '0;
  assign sts_cur  = |(sts_s2 & cur_mask);
  assign rst_low  = (state == ST_RST) && (timer < RST_LOW);
  assign tx_load  = (state == ST_FETCH) && (timer != '0);

  assign busy_o         = (state != ST_IDLE);
  assign done_o         = done;
  assign err_o          = err;
  assign lock_o         = sts_s2 & done;
  assign cfg_chip_o     = cur;
  assign cfg_idx_o      = idx;
  assign AD9516_RESET_B = ~(cur_mask & {N_CHIP{rst_low}});
  assign AD9516_PD_B    = '1;
  assign AD9516_REFSEL  = refsel_q;

  // Edge detect (reset high so a held start is not an edge), request queue, STATUS sync
  always_ff @(posedge sys_clk_i or negedge hw_arst_n) begin
    if (!hw_arst_n) begin
      start_q  <= '1;
      pend     <= '0;
      sts_s1   <= '0;
      sts_s2   <= '0;
      refsel_q <= '0;
    end else begin
      start_q  <= start_i;
      pend     <= (pend & ~pend_clr) | rise;
      sts_s1   <= AD9516_STATUS;
      sts_s2   <= sts_s1;
      refsel_q <= refsel_i;
    end
  end

  // Service sequencer: reset pulse, table walk, lock wait with bounded retries
  always_ff @(posedge sys_clk_i or negedge hw_arst_n) begin
    if (!hw_arst_n) begin
      state  <= ST_IDLE;
      cur    <= '0;
      last   <= 2'(N_CHIP - 1);
      idx    <= '0;
      retry  <= '0;
      timer  <= '0;
      stable <= '0;
      done   <= '0;
      err    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (|pend) state <= ST_ARB;
        ST_ARB: begin
          if (found) begin
            cur   <= grant;
            done  <= done & ~grant_mask;
            err   <= err & ~grant_mask;
            retry <= '0;
            idx   <= '0;
            timer <= '0;
            state <= ST_RST;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RST: begin
          if (timer == RST_LAST) begin
            timer <= '0;
            state <= ST_FETCH;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_FETCH: begin
          if (timer == '0) begin
            timer <= TMR_W'(1);
          end else begin
            timer <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (!tx_busy) begin
            timer <= '0;
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (timer == GAP_LAST) begin
            timer <= '0;
            if (idx == IDX_LAST) begin
              stable <= '0;
              state  <= ST_LOCK;
            end else begin
              idx   <= idx + 8'd1;
              state <= ST_FETCH;
            end
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_LOCK: begin
          if (timer != '1) timer <= timer + TMR_W'(1);
          if (!sts_cur) stable <= '0;
          else if (stable != 4'd15) stable <= stable + 4'd1;
          if (sts_cur && stable == 4'd15) begin
            done  <= done | cur_mask;
            last  <= cur;
            state <= (|pend) ? ST_ARB : ST_IDLE;
          end else if (timer >= TO_LAST) begin
            if (retry < RTY_W'(MAX_RETRY)) begin
              retry <= retry + RTY_W'(1);
              idx   <= '0;
              timer <= '0;
              state <= ST_RST;
            end else begin
              err   <= err | cur_mask;
              done  <= done | cur_mask;
              last  <= cur;
              state <= (|pend) ? ST_ARB : ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ad9516_spi_tx #(
    .N_CHIP  (N_CHIP),
    .SCLK_DIV(SCLK_DIV)
  ) u_spi_tx (
    .clk  (sys_clk_i),
    .rst_n(hw_arst_n),
    .load (tx_load),
    .sel  (cur),
    .word (cfg_word_i),
    .busy (tx_busy),
    .cs   (AD9516_CS),
    .sclk (AD9516_SCLK),
    .sdio (AD9516_SDIO)
  );

endmodule

// File: tb/tb_ad9516_multi_cfg.sv
// Directed bench for the two-chip configurator with a short table and fast SCLK.
// A negedge monitor decodes SPI frames and RESET_B pulses per chip.
// The main sequence compares monitor tallies and DUT flags against fixed expectations.
module tb_ad9516_multi_cfg;

  logic        clk = 1'b0;
  logic        hw_arst_n;
  logic [1:0]  start_i, refsel_i, status;
  logic [1:0]  cfg_chip;
  logic [7:0]  cfg_idx;
  logic [23:0] cfg_word;
  logic [1:0]  cs, sclk, sdio, rstb, pdb, refsel_o;
  logic        busy;
  logic [1:0]  done, lock, err;

  int n_total = 0, n_pass = 0, n_fail = 0;

  ad9516_multi_cfg #(
    .N_CHIP(2), .REG_NUM(4), .SCLK_DIV(2),
    .LOCK_TIMEOUT(500), .MAX_RETRY(2), .RST_LEN(16)
  ) dut (
    .sys_clk_i(clk), .hw_arst_n(hw_arst_n),
    .start_i(start_i), .refsel_i(refsel_i),
    .cfg_chip_o(cfg_chip), .cfg_idx_o(cfg_idx), .cfg_word_i(cfg_word),
    .AD9516_CS(cs), .AD9516_SCLK(sclk), .AD9516_SDIO(sdio),
    .AD9516_RESET_B(rstb), .AD9516_PD_B(pdb), .AD9516_REFSEL(refsel_o),
    .AD9516_STATUS(status),
    .busy_o(busy), .done_o(done), .lock_o(lock), .err_o(err)
  );

  always #5 clk = ~clk;

  // Table contents: chip in [23:20], entry index in [15:8], data 0x99
  function automatic logic [23:0] tbl(input int c, input int i);
    tbl = {4'(c), 4'h0, 8'(i), 8'h99};
  endfunction

  // Synchronous table read: word valid one cycle after the address
  always @(posedge clk) cfg_word <= tbl(int'(cfg_chip), int'(cfg_idx));

  // Frame / reset-pulse monitor
  int frames[2] = '{0, 0};
  int pulses[2] = '{0, 0};
  int bits[2]   = '{0, 0};
  int cslen[2]  = '{0, 0};
  int rlow[2]   = '{0, 0};
  int seq[2]    = '{0, 0};
  logic [23:0] sh[2];
  logic [23:0] last_word[2];
  logic [1:0] p_cs = 2'b11, p_sclk = 2'b00, p_sdio = 2'b00, p_rstb = 2'b11;
  int bad_len = 0, bad_word = 0, bad_sdio = 0, bad_idle = 0, bad_both = 0, bad_rst = 0;
  int frame_log[$];

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!hw_arst_n) begin
        bits[c] = 0; cslen[c] = 0; seq[c] = 0; rlow[c] = 0;
      end else begin
        if (!cs[c]) cslen[c]++;
        if (sclk[c] && !p_sclk[c]) begin
          sh[c] = {sh[c][22:0], sdio[c]};
          bits[c]++;
        end
        if (sdio[c] !== p_sdio[c] && sclk[c]) bad_sdio++;
        if (cs[c] && (sclk[c] || sdio[c])) bad_idle++;
        if (cs[c] && !p_cs[c]) begin
          frames[c]++;
          frame_log.push_back(c);
          last_word[c] = sh[c];
          if (cslen[c] != 96 || bits[c] != 24) bad_len++;
          if (sh[c] !== tbl(c, seq[c])) bad_word++;
          seq[c]++;
          cslen[c] = 0;
          bits[c]  = 0;
        end
        if (!rstb[c]) rlow[c]++;
        if (rstb[c] && !p_rstb[c]) begin
          pulses[c]++;
          if (rlow[c] != 16) bad_rst++;
          rlow[c] = 0;
          seq[c]  = 0;
        end
      end
    end
    if (!cs[0] && !cs[1]) bad_both++;
    p_cs = cs; p_sclk = sclk; p_sdio = sdio; p_rstb = rstb;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  int f0, f1, p0, p1, base, n;
  logic [7:0] ord;

  initial begin
    hw_arst_n = 1'b0; start_i = 2'b10; refsel_i = 2'b10; status = 2'b00;
    repeat (3) tick();
    check("rst_cs", 32'(cs), 32'h3);
    check("rst_sclk", 32'(sclk), 32'h0);
    check("rst_sdio", 32'(sdio), 32'h0);
    check("rst_resetb", 32'(rstb), 32'h3);
    check("rst_pdb", 32'(pdb), 32'h3);
    check("rst_refsel", 32'(refsel_o), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_flags", {26'b0, done, lock, err}, 32'h0);
    check("rst_cfg_addr", {22'b0, cfg_chip, cfg_idx}, 32'h0);

    // Release with start_i[1] already high: must not count as an edge
    hw_arst_n = 1'b1;
    repeat (40) tick();
    check("held_start_busy", 32'(busy), 32'h0);
    check("held_start_frames", 32'(frames[1]), 32'h0);
    check("refsel_reg", 32'(refsel_o), 32'h2);
    start_i = 2'b00;
    tick();

    // Chip 0: four frames, lock arrives late but inside the window
    start_i = 2'b01; tick(); start_i = 2'b00; tick(); tick();
    check("a_busy_rise", 32'(busy), 32'h1);
    n = 0;
    while (frames[0] < 4 && n < 2000) begin tick(); n++; end
    check("a_frames0", 32'(frames[0]), 32'd4);
    check("a_frames1", 32'(frames[1]), 32'd0);
    check("a_last_word", 32'(last_word[0]), 32'h000399);
    check("a_pulses", {pulses[1][15:0], pulses[0][15:0]}, 32'h0000_0001);
    repeat (100) tick();
    status[0] = 1'b1;
    wait_idle(1000, "a_busy_fall");
    check("a_done", 32'(done), 32'h1);
    check("a_lock", 32'(lock), 32'h1);
    check("a_err", 32'(err), 32'h0);
    check("a_no_extra", 32'(frames[0]), 32'd4);
    status[0] = 1'b0; repeat (4) tick();
    check("a_lock_follow_low", 32'(lock), 32'h0);
    check("a_done_kept", 32'(done), 32'h1);
    status[0] = 1'b1; repeat (4) tick();
    check("a_lock_follow_high", 32'(lock), 32'h1);

    // Chip 1 never locks: first try plus two retries, then error
    f1 = frames[1]; p1 = pulses[1];
    start_i = 2'b10; tick(); start_i = 2'b00; tick(); tick();
    wait_idle(6000, "b_busy_fall");
    check("b_frames", 32'(frames[1] - f1), 32'd12);
    check("b_pulses", 32'(pulses[1] - p1), 32'd3);
    check("b_err", 32'(err), 32'h2);
    check("b_done", 32'(done), 32'h3);
    check("b_lock", 32'(lock), 32'h1);
    check("b_chip0_quiet", 32'(frames[0]), 32'd4);

    // Simultaneous requests: chip 0 fully first, busy never drops between
    status[1] = 1'b1;
    base = frame_log.size();
    start_i = 2'b11; tick(); start_i = 2'b00; tick(); tick();
    wait_idle(4000, "c_busy_fall");
    check("c_frame_count", 32'(frame_log.size() - base), 32'd8);
    ord = 8'hFF;
    if (frame_log.size() >= base + 8)
      for (int k = 0; k < 8; k++) ord[k] = frame_log[base + k][0];
    check("c_order", 32'(ord), 32'hF0);
    check("c_done", 32'(done), 32'h3);
    check("c_lock", 32'(lock), 32'h3);
    check("c_err", 32'(err), 32'h0);

    check("mon_len", 32'(bad_len), 32'd0);
    check("mon_word", 32'(bad_word), 32'd0);
    check("mon_sdio_stable", 32'(bad_sdio), 32'd0);
    check("mon_idle_lines", 32'(bad_idle), 32'd0);
    check("mon_one_cs", 32'(bad_both), 32'd0);
    check("mon_rst_len", 32'(bad_rst), 32'd0);

    // Reset in the middle of frame 2, bit 10
    f0 = frames[0];
    start_i = 2'b01; tick(); start_i = 2'b00;
    n = 0;
    while (frames[0] < f0 + 1 && n < 1000) begin tick(); n++; end
    check("d_frame1_seen", 32'(frames[0] - f0), 32'd1);
    n = 0;
    while (bits[0] < 10 && n < 200) begin tick(); n++; end
    check("d_bit10", 32'(bits[0]), 32'd10);
    hw_arst_n = 1'b0;
    #1;
    check("d_cs", 32'(cs), 32'h3);
    check("d_sclk", 32'(sclk), 32'h0);
    check("d_sdio", 32'(sdio), 32'h0);
    check("d_busy", 32'(busy), 32'h0);
    check("d_flags", {26'b0, done, lock, err}, 32'h0);
    repeat (3) tick();
    hw_arst_n = 1'b1;
    f0 = frames[0]; f1 = frames[1]; p0 = pulses[0]; p1 = pulses[1];
    repeat (1500) tick();
    check("d_no_frames", 32'((frames[0] - f0) + (frames[1] - f1)), 32'd0);
    check("d_no_pulses", 32'((pulses[0] - p0) + (pulses[1] - p1)), 32'd0);
    check("d_idle", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
